// File: rtl/sp_ram_arbiter.sv
// Shares one single-port RAM between NUM_REQ valid/ready requesters: write = 1 RAM cycle, read = address + data phase.
// Define SP_RAM_ARB_FIXED_PRIO_EN for lowest-index-wins arbitration; the default build is round-robin.
module sp_ram_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic [ADDR_WIDTH-1:0]         ram_addr,
    output logic                          ram_cs,
    output logic                          ram_we,
    output logic                          ram_oe,
    inout  wire  [DATA_WIDTH-1:0]         ram_data
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, WRITE, RD_ADDR, RD_DATA} state_t;

    state_t                state, state_n;
    logic [IDX_W-1:0]      win;
    logic                  any_vld;
    logic                  grant;
    logic                  win_we;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [DATA_WIDTH-1:0] win_wdata;
    logic [NUM_REQ-1:0]    owner_oh;
    logic [DATA_WIDTH-1:0] wdata_p0;
    logic [IDX_W-1:0]      owner_p0;

`ifdef SP_RAM_ARB_FIXED_PRIO_EN
    always_comb begin
        win     = '0;
        any_vld = 1'b0;
        // Descending scan so the lowest valid index is the last (winning) assignment.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[k]) begin
                win     = IDX_W'(k);
                any_vld = 1'b1;
            end
        end
    end
`else
    logic [IDX_W-1:0] rr_ptr;
    int               scan_idx;

    always_comb begin
        win      = '0;
        any_vld  = 1'b0;
        scan_idx = 0;
        // Scan offsets high to low so the requester closest to rr_ptr wins.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            scan_idx = int'(rr_ptr) + k;
            if (scan_idx >= NUM_REQ) scan_idx = scan_idx - NUM_REQ;
            if (req_valid[IDX_W'(scan_idx)]) begin
                win     = IDX_W'(scan_idx);
                any_vld = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        win_we    = 1'b0;
        win_addr  = '0;
        win_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win == IDX_W'(i)) begin
                win_we    = req_we[i];
                win_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                win_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign grant = (state == IDLE) && any_vld && !rst;

    always_comb begin
        req_ready = '0;
        owner_oh  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = grant && (win == IDX_W'(i));
            owner_oh[i]  = (owner_p0 == IDX_W'(i));
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (grant) state_n = win_we ? WRITE : RD_ADDR;
            WRITE:   state_n = IDLE;
            RD_ADDR: state_n = RD_DATA;
            RD_DATA: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Stage p0: controls registered from the next state so the RAM sees clean pins.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ram_cs    <= 1'b0;
            ram_we    <= 1'b0;
            ram_oe    <= 1'b0;
            ram_addr  <= '0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
`ifndef SP_RAM_ARB_FIXED_PRIO_EN
            rr_ptr    <= '0;
`endif
        end else begin
            state  <= state_n;
            ram_cs <= (state_n != IDLE);
            ram_we <= (state_n == WRITE);
            ram_oe <= (state_n == RD_DATA);
            if (grant) begin
                ram_addr <= win_addr;
`ifndef SP_RAM_ARB_FIXED_PRIO_EN
                rr_ptr   <= (win == IDX_W'(NUM_REQ - 1)) ? '0 : win + IDX_W'(1);
`endif
            end else if (state_n == IDLE) begin
                ram_addr <= '0;
            end
            rsp_valid <= (state == RD_DATA) ? owner_oh : '0;
            if (state == RD_DATA) rsp_rdata <= ram_data;
        end
    end

    always_ff @(posedge clk) begin
        if (grant) begin
            wdata_p0 <= win_wdata;
            owner_p0 <= win;
        end
    end

    // The bus is only ever driven while ram_we is high, which never overlaps ram_oe.
    assign ram_data = ram_we ? wdata_p0 : 'z;

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Bench for sp_ram_arbiter: bench-side RAM, transaction-level reference model, directed tests.
module tb_sp_ram_arbiter;
  localparam int NUM_REQ = 2;
  localparam int ADDR_W  = 4;
  localparam int DATA_W  = 32;

  logic                       clk = 1'b0;
  logic                       rst;
  logic [NUM_REQ-1:0]         req_valid, req_ready, req_we, rsp_valid;
  logic [NUM_REQ*ADDR_W-1:0]  req_addr;
  logic [NUM_REQ*DATA_W-1:0]  req_wdata;
  logic [DATA_W-1:0]          rsp_rdata;
  logic [ADDR_W-1:0]          ram_addr;
  logic                       ram_cs, ram_we, ram_oe;
  wire  [DATA_W-1:0]          ram_data;

  always #5 clk = ~clk;

  sp_ram_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_WIDTH(ADDR_W), .DATA_WIDTH(DATA_W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .ram_addr(ram_addr), .ram_cs(ram_cs), .ram_we(ram_we), .ram_oe(ram_oe), .ram_data(ram_data)
  );

  // Single-port RAM: write on cs&we, read register loaded on cs&!we, driven out while oe.
  logic              ram_clr;
  logic [DATA_W-1:0] ram_mem [16];
  logic [DATA_W-1:0] ram_rd;
  assign ram_data = (ram_cs && ram_oe && !ram_we) ? ram_rd : 'z;
  always @(posedge clk) begin
    if (ram_clr) begin
      for (int a = 0; a < 16; a++) ram_mem[a] <= '0;
    end else if (ram_cs && ram_we) begin
      ram_mem[ram_addr] <= ram_data;
    end else if (ram_cs) begin
      ram_rd <= ram_mem[ram_addr];
    end
  end

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } op_t;

  op_t qs [NUM_REQ][$];

  function automatic op_t mk(input logic we, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
    op_t o;
    o.we = we; o.addr = addr; o.data = data;
    return o;
  endfunction

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model state and logs
  bit                mon_en = 1'b0;
  int                ncyc = 0;
  int                m_phase = 0, m_rr = 0, m_owner = 0, m_rsp_owner = 0;
  bit                m_we = 1'b0, m_rsp_pend = 1'b0;
  logic [ADDR_W-1:0] m_addr = '0;
  logic [DATA_W-1:0] m_data = '0, m_rdata = '0;
  logic [DATA_W-1:0] m_mem [16];
  int                glog[$], gclog[$], rclog[$];
  logic [DATA_W-1:0] rlog[$];
  logic [NUM_REQ-1:0] rvlog[$];
  int                we_cnt = 0, rsp_cnt = 0;

  function automatic int gq(input int k);  return (k < glog.size())  ? glog[k]  : -1; endfunction
  function automatic int gcq(input int k); return (k < gclog.size()) ? gclog[k] : -1000; endfunction
  function automatic int rcq(input int k); return (k < rclog.size()) ? rclog[k] : -1000; endfunction
  function automatic logic [DATA_W-1:0] rq(input int k);  return (k < rlog.size())  ? rlog[k]  : 'x; endfunction
  function automatic logic [NUM_REQ-1:0] rvq(input int k); return (k < rvlog.size()) ? rvlog[k] : 'x; endfunction

  initial begin : compare
    int win, idx;
    logic [NUM_REQ-1:0] exp_ready, exp_rsp;
    for (int a = 0; a < 16; a++) m_mem[a] = '0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        ncyc++;
        win = -1;
        if (m_phase == 0 && !rst) begin
          for (int k = 0; k < NUM_REQ; k++) begin
`ifdef SP_RAM_ARB_FIXED_PRIO_EN
            idx = k;
`else
            idx = (m_rr + k) % NUM_REQ;
`endif
            if (win < 0 && req_valid[idx]) win = idx;
          end
        end
        exp_ready = '0;
        if (win >= 0) exp_ready[win] = 1'b1;
        exp_rsp = '0;
        if (m_rsp_pend) exp_rsp[m_rsp_owner] = 1'b1;

        chk("req_ready", req_ready, exp_ready);
        chk("ready_onehot", $countones(req_ready) <= 1, 1);
        chk("ram_cs", ram_cs, m_phase != 0);
        chk("ram_we", ram_we, m_phase == 1 && m_we);
        chk("ram_oe", ram_oe, m_phase == 2);
        chk("ram_addr", ram_addr, (m_phase != 0) ? m_addr : '0);
        chk("rsp_valid", rsp_valid, exp_rsp);
        chk("rsp_rdata", rsp_rdata, m_rdata);
        chk("bus_drive_with_oe", ram_we & ram_oe, 0);
        if (m_phase == 1 && m_we) chk("ram_data_wr", ram_data, m_data);

        if (ram_we) we_cnt++;
        if (rsp_valid != '0) begin
          rsp_cnt++;
          rlog.push_back(rsp_rdata);
          rvlog.push_back(rsp_valid);
          rclog.push_back(ncyc);
        end

        if (rst) begin
          if (m_phase == 1 && m_we) m_mem[m_addr] = m_data;
          m_phase = 0; m_rr = 0; m_rsp_pend = 1'b0; m_rdata = '0;
        end else begin
          m_rsp_pend = 1'b0;
          if (m_phase == 1 && m_we) begin
            m_mem[m_addr] = m_data; m_phase = 0;
          end else if (m_phase == 1) begin
            m_phase = 2;
          end else if (m_phase == 2) begin
            m_rsp_pend = 1'b1; m_rsp_owner = m_owner; m_rdata = m_mem[m_addr]; m_phase = 0;
          end else if (win >= 0) begin
            m_owner = win;
            m_we    = req_we[win];
            m_addr  = req_addr[win*ADDR_W +: ADDR_W];
            m_data  = req_wdata[win*DATA_W +: DATA_W];
            m_phase = 1;
            m_rr    = (win + 1) % NUM_REQ;
            glog.push_back(win);
            gclog.push_back(ncyc);
          end
        end
      end
    end
  end

  // Requesters: present queue heads, hold until accepted.
  initial begin : driver
    logic [NUM_REQ-1:0] acc;
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    forever begin
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (acc[i] && qs[i].size() > 0) void'(qs[i].pop_front());
        if (qs[i].size() > 0) begin
          req_valid[i] = 1'b1;
          req_we[i]    = qs[i][0].we;
          req_addr[i*ADDR_W +: ADDR_W]  = qs[i][0].addr;
          req_wdata[i*DATA_W +: DATA_W] = qs[i][0].data;
        end else begin
          req_valid[i] = 1'b0;
        end
      end
    end
  end

  task automatic wait_done(input int budget);
    int n = 0, quiet = 0;
    bit empty;
    while (quiet < 4 && n < budget) begin
      @(negedge clk);
      n++;
      empty = 1'b1;
      for (int i = 0; i < NUM_REQ; i++) if (qs[i].size() != 0) empty = 1'b0;
      if (empty && req_valid == '0 && m_phase == 0) quiet++;
      else quiet = 0;
    end
    chk("wait_done_in_budget", quiet >= 4, 1);
  endtask

  task automatic wait_accept(input int r);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(req_valid[r] && req_ready[r]) && n < 20);
    chk("accept_seen", req_valid[r] && req_ready[r], 1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int gb, rb, cb, nrd;
    int exp_g [4];
    op_t o;
    rst = 1'b1; ram_clr = 1'b1;
`ifdef SP_RAM_ARB_FIXED_PRIO_EN
    exp_g = '{0, 0, 1, 1};
`else
    exp_g = '{0, 1, 0, 1};
`endif
    // Contending reads queued while still in reset
    qs[0].push_back(mk(1'b0, 4'd1, '0)); qs[0].push_back(mk(1'b0, 4'd1, '0));
    qs[1].push_back(mk(1'b0, 4'd2, '0)); qs[1].push_back(mk(1'b0, 4'd2, '0));
    @(posedge clk); #1; mon_en = 1'b1;
    @(negedge clk);
    chk("rst_ready_low", req_ready, 2'b00);
    chk("rst_ram_ctrl", {ram_cs, ram_we, ram_oe, ram_addr}, '0);
    chk("rst_rsp", {rsp_valid, rsp_rdata}, '0);
    @(posedge clk); #1; rst = 1'b0; ram_clr = 1'b0;
    wait_done(100);
    chk("rr_grant_count", glog.size(), 4);
    for (int k = 0; k < 4; k++) chk("rr_grant_order", gq(k), exp_g[k]);
    for (int k = 0; k < 3; k++) chk("rr_read_spacing", gcq(k + 1) - gcq(k), 3);

    // Single write then read, requester 0
    cb = we_cnt;
    qs[0].push_back(mk(1'b1, 4'd3, 32'hDEADBEEF));
    wait_done(100);
    chk("t1_we_cycles", we_cnt - cb, 1);
    gb = glog.size(); rb = rlog.size();
    qs[0].push_back(mk(1'b0, 4'd3, '0));
    wait_done(100);
    chk("t1_rsp_count", rlog.size() - rb, 1);
    chk("t1_rdata", rq(rb), 32'hDEADBEEF);
    chk("t1_rsp_owner", rvq(rb), 2'b01);
    chk("t1_rsp_latency", rcq(rb) - gcq(gb), 3);

    // Cross-requester read-after-write
    rb = rlog.size();
    qs[1].push_back(mk(1'b1, 4'd5, 32'h12345678));
    wait_accept(1);
    qs[0].push_back(mk(1'b0, 4'd5, '0));
    wait_done(100);
    chk("raw_rdata", rq(rb), 32'h12345678);
    chk("raw_owner", rvq(rb), 2'b01);

    // Reset during RD_ADDR
    cb = rsp_cnt;
    qs[0].push_back(mk(1'b0, 4'd5, '0));
    wait_accept(0);
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    chk("midrd_in_rd_addr", {ram_cs, ram_we, ram_oe}, 3'b100);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("midrd_ram_idle", {ram_cs, ram_we, ram_oe, ram_addr}, '0);
    repeat (4) @(negedge clk);
    chk("midrd_no_rsp", rsp_cnt - cb, 0);
    gb = glog.size(); rb = rlog.size();
    qs[1].push_back(mk(1'b0, 4'd5, '0));
    qs[0].push_back(mk(1'b0, 4'd3, '0));
    wait_done(100);
    chk("post_rst_first_grant", gq(gb), 0);
    chk("post_rst_second_grant", gq(gb + 1), 1);
    chk("post_rst_rdata0", rq(rb), 32'hDEADBEEF);
    chk("post_rst_rdata1", rq(rb + 1), 32'h12345678);

    // Back-to-back writes from requester 1, then full readback
    gb = glog.size();
    for (int a = 0; a < 16; a++) qs[1].push_back(mk(1'b1, ADDR_W'(a), DATA_W'(a * 3)));
    wait_done(200);
    for (int k = 1; k < 16; k++) chk("b2b_write_spacing", gcq(gb + k) - gcq(gb + k - 1), 2);
    rb = rlog.size();
    for (int a = 0; a < 16; a++) qs[1].push_back(mk(1'b0, ADDR_W'(a), '0));
    wait_done(200);
    chk("readback_count", rlog.size() - rb, 16);
    for (int k = 0; k < 16; k++) chk("readback_data", rq(rb + k), DATA_W'(k * 3));

    // Random mix of 200 operations across both requesters
    gb = glog.size(); cb = rsp_cnt; nrd = 0;
    for (int n = 0; n < 200; n++) begin
      o = mk(1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 15)), DATA_W'($urandom));
      if (!o.we) nrd++;
      qs[$urandom_range(0, NUM_REQ - 1)].push_back(o);
    end
    wait_done(3000);
    chk("rand_grant_count", glog.size() - gb, 200);
    chk("rand_rsp_count", rsp_cnt - cb, nrd);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/sp_ram_arbiter.md
Name: sp_ram_arbiter

Overview:
Round-robin arbiter and sequencer that shares one single_port_RAM instance between NUM_REQ requesters. It is the sole master on the RAM's addr/cs/we/oe pins and its bidirectional data bus. It converts per-requester valid/ready requests into correctly timed RAM write and two-phase read cycles, and returns read data on a per-requester response strobe.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
ADDR_WIDTH, 4, RAM address width
DATA_WIDTH, 32, RAM data width
IDX_W, $clog2(NUM_REQ) (min 1), requester index width (derived, do not override)

Ports:
clk  input  1  clock, all logic on posedge
rst  input  1  synchronous active-high reset
req_valid  input  NUM_REQ  per-requester request valid
req_ready  output  NUM_REQ  per-requester accept, at most one bit high
req_we  input  NUM_REQ  1=write, 0=read, per requester
req_addr  input  NUM_REQ*ADDR_WIDTH  packed addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
req_wdata  input  NUM_REQ*DATA_WIDTH  packed write data
rsp_valid  output  NUM_REQ  one-cycle read-data strobe to the owning requester
rsp_rdata  output  DATA_WIDTH  read data, shared bus, valid while any rsp_valid bit is high
ram_addr  output  ADDR_WIDTH  to RAM addr
ram_cs  output  1  to RAM cs
ram_we  output  1  to RAM we
ram_oe  output  1  to RAM oe
ram_data  inout  DATA_WIDTH  to RAM data; driven only in WRITE, otherwise high-Z

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high. Ports are clk and rst.
- Reset values: state=IDLE, ram_cs=ram_we=ram_oe=0, ram_addr=0, ram_data high-Z, rsp_valid=0, rsp_rdata=0, rr_ptr=0, req_ready=0 during the rst cycle.
- All ram_* controls are registered. req_ready is combinational from state, req_valid and rr_ptr.
- FSM states: IDLE, WRITE, RD_ADDR, RD_DATA.
- IDLE:
  - If any req_valid is set, the arbiter picks winner g, the first set bit scanning g = rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - It raises req_ready[g] only, and latches addr, we, wdata and g at the edge.
  - It sets rr_ptr = (g+1) mod NUM_REQ.
  - Next state is WRITE if we=1, else RD_ADDR.
  - With no req_valid set, it stays in IDLE with all ram_* = 0.
- WRITE (1 cycle): cs=1, we=1, oe=0, ram_data driven with the latched wdata. The RAM writes at the closing edge. Next state is IDLE.
- RD_ADDR (1 cycle): cs=1, we=0, oe=0. The RAM loads its read register at the closing edge. Next state is RD_DATA.
- RD_DATA (1 cycle): cs=1, we=0, oe=1, ram_data high-Z. rsp_rdata captures ram_data at the closing edge. Next state is IDLE.
- Response: rsp_valid[g] is high for exactly the one cycle after RD_DATA. rsp_rdata holds its value until the next read capture.
- Latency from accept edge E:
  - Write committed at E+1.
  - Read response visible during cycle E+2..E+3.
  - Throughput: write = 2 cycles/op, read = 3 cycles/op.
- Handshake rules:
  - A requester holds req_valid and its payload stable until req_ready.
  - req_ready is never high outside IDLE.
  - Dropping req_valid before ready is allowed; nothing is issued.
  - Responses have no backpressure.
- Bus safety: ram_data is driven only while ram_we=1. The controller never drives the bus in the same cycle as ram_oe=1.
- Ordering: operations complete strictly in grant order. A read issued after another requester's write to the same address returns the new data.
- Reset mid-operation: the FSM returns to IDLE at the rst edge. The in-flight op is dropped, no rsp_valid is issued, and the bus is high-Z from the next cycle. A write whose WRITE cycle coincides with rst still commits, because the RAM has no reset.
- rr_ptr updates only on a grant.

Optional Feature:
SP_RAM_ARB_FIXED_PRIO_EN
- Defined: fixed priority. The lowest-index valid requester always wins; rr_ptr is removed.
- Undefined (default): round-robin as described above.
- Timing, FSM and handshake are identical in both builds.

Test Plan:
- Single write then read, requester 0: write addr 3 data 0xDEADBEEF, then read addr 3 -> ram_we high exactly 1 cycle; rsp_valid[0] one pulse 2 cycles after the read accept edge; rsp_rdata=0xDEADBEEF; rsp_valid[1] stays 0.
- Round-robin contention: both requesters hold valid reads (addr 1, addr 2) continuously after reset -> grants alternate 0,1,0,1. Under SP_RAM_ARB_FIXED_PRIO_EN, requester 0 wins every time.
- Cross-requester RAW: req1 writes addr 5 = 0x12345678 while req0 waits to read addr 5 -> req0 receives 0x12345678.
- Bus contention check: random mix of 200 ops -> ram_data is never driven while ram_oe=1, and req_ready is never high outside IDLE or on more than one bit.
- Reset mid-read: assert rst during RD_ADDR -> no rsp_valid; all ram_* = 0 next cycle; the next request is served normally with rr_ptr=0.
- Back-to-back writes, requester 1: addrs 0..15 with data = addr*3 -> each op takes 2 cycles; a readback of all 16 addresses matches.
